// File: rtl/ka_pkg.sv
// Shared types and default sizing for the ka_fork_ctrl fork/join handshake controller.
package ka_pkg;

    typedef enum logic {
        KA_IDLE = 1'b0,
        KA_BUSY = 1'b1
    } ka_state_t;

    localparam int KA_NCH_DEF       = 4;
    localparam int KA_TMO_W_DEF     = 10;
    localparam int KA_TMO_LIMIT_DEF = 1000;
    localparam int KA_CNT_W_DEF     = 16;

endpackage

// File: rtl/ka_fork_ctrl_if.sv
// Upstream req/ack plus channel mask, and NCH downstream req/ack lanes, as one bundle.
interface ka_fork_ctrl_if
    import ka_pkg::*;
#(
    parameter int NCH = KA_NCH_DEF
);
    // Four-phase-free req/ack: a requester raises req and holds it (and its payload,
    // here t_mask) until it sees ack high in the same cycle; that cycle completes the
    // transfer and req may drop or start a new transfer in the next cycle.
    logic           t_ka_req;
    logic           t_ka_ack;
    logic [NCH-1:0] t_mask;
    logic [NCH-1:0] i_req;
    logic [NCH-1:0] i_ack;

    modport master (
        output t_ka_req, t_mask, i_ack,
        input  t_ka_ack, i_req
    );

    modport slave (
        input  t_ka_req, t_mask, i_ack,
        output t_ka_ack, i_req
    );

endinterface

// File: rtl/ka_fork_lane.sv
// One downstream channel: remembers whether this channel already acked in the
// current transaction and produces its request and its contribution to the join.
module ka_fork_lane
    import ka_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic sel,
    input  logic ack,
    input  logic txn_ack,
    output logic i_req,
    output logic term,
    output logic done
);

    logic done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (done_q | (i_req & ack)) & ~txn_ack;
        end
    end

    assign i_req = req & sel & ~done_q;
    // Channel is satisfied if unselected, already done, or acking right now.
    assign term  = ~sel | done_q | ack;
    assign done  = done_q;

endmodule

// File: rtl/ka_fork_ctrl.sv
// Fork/join controller: fans one upstream request out to the masked channels and
// acks upstream once every selected channel has acked; adds a counter and watchdog.
module ka_fork_ctrl
    import ka_pkg::*;
#(
    parameter int NCH       = KA_NCH_DEF,
    parameter int TMO_W     = KA_TMO_W_DEF,
    parameter int TMO_LIMIT = KA_TMO_LIMIT_DEF,
    parameter int CNT_W     = KA_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    ka_fork_ctrl_if.slave     ka,
    input  logic              err_clr,
    output logic              err_tmo,
    output logic [NCH-1:0]    err_ch,
    output logic [CNT_W-1:0]  txn_cnt,
    output ka_state_t         state
);

    localparam logic [TMO_W-1:0] WD_LIMIT   = TMO_W'(TMO_LIMIT);
    localparam logic [TMO_W-1:0] WD_LAST    = TMO_W'(TMO_LIMIT - 1);

    ka_state_t        state_q;
    ka_state_t        state_d;
    logic [NCH-1:0]   mask_q;
    logic [NCH-1:0]   mask_eff;
    logic [NCH-1:0]   lane_req;
    logic [NCH-1:0]   lane_term;
    logic [NCH-1:0]   lane_done;
    logic [TMO_W-1:0] wcnt_q;
    logic [CNT_W-1:0] txn_cnt_q;
    logic [NCH-1:0]   err_ch_q;
    logic             err_tmo_q;
    logic             req_live;
    logic             txn_ack;
    logic             tmo_evt;

    // Gating with reset_n makes an asserted reset drop every downstream request at once.
    assign req_live = ka.t_ka_req & reset_n;
    assign mask_eff = (state_q == KA_IDLE) ? ka.t_mask : mask_q;
    assign txn_ack  = req_live & (&lane_term);

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        ka_fork_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req_live),
            .sel     (mask_eff[g]),
            .ack     (ka.i_ack[g]),
            .txn_ack (txn_ack),
            .i_req   (lane_req[g]),
            .term    (lane_term[g]),
            .done    (lane_done[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            KA_IDLE: if (req_live && !txn_ack) state_d = KA_BUSY;
            KA_BUSY: if (txn_ack)              state_d = KA_IDLE;
            default:                           state_d = KA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= KA_IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == KA_IDLE && state_d == KA_BUSY) begin
                mask_q <= ka.t_mask;
            end
        end
    end

    // Fires once per stall, on the cycle the watchdog reaches its limit.
    assign tmo_evt = (state_q == KA_BUSY) & ~txn_ack & (wcnt_q == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q    <= '0;
            err_tmo_q <= 1'b0;
            err_ch_q  <= '0;
            txn_cnt_q <= '0;
        end else begin
            if (state_q == KA_IDLE || txn_ack) begin
                wcnt_q <= '0;
            end else if (wcnt_q != WD_LIMIT) begin
                wcnt_q <= wcnt_q + TMO_W'(1);
            end

            if (tmo_evt) begin
                err_tmo_q <= 1'b1;
                err_ch_q  <= err_ch_q | (mask_q & ~lane_done & ~ka.i_ack);
            end else if (err_clr) begin
                err_tmo_q <= 1'b0;
                err_ch_q  <= '0;
            end

            if (txn_ack) begin
                txn_cnt_q <= txn_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ka.t_ka_ack = txn_ack;
    assign ka.i_req    = lane_req;
    assign err_tmo     = err_tmo_q;
    assign err_ch      = err_ch_q;
    assign txn_cnt     = txn_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ka_fork_ctrl.sv
// Directed and randomized bench for ka_fork_ctrl against a transaction-level model.
module tb_ka_fork_ctrl;
    import ka_pkg::*;

    localparam int NCH       = 4;
    localparam int TMO_W     = 10;
    localparam int TMO_LIMIT = 20;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             err_clr;
    logic             err_tmo;
    logic [NCH-1:0]   err_ch;
    logic [CNT_W-1:0] txn_cnt;
    ka_state_t        state;

    int checks = 0;
    int errors = 0;

    ka_fork_ctrl_if #(.NCH(NCH)) bus ();

    ka_fork_ctrl #(
        .NCH(NCH), .TMO_W(TMO_W), .TMO_LIMIT(TMO_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ka      (bus),
        .err_clr (err_clr),
        .err_tmo (err_tmo),
        .err_ch  (err_ch),
        .txn_cnt (txn_cnt),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Upstream must hold its request until acked.
    logic pend_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
        end else begin
            assert (!(pend_q && !bus.t_ka_req))
                else $error("protocol: t_ka_req dropped before t_ka_ack");
            pend_q <= bus.t_ka_req && !bus.t_ka_ack;
        end
    end

    // Transaction-level model: open transaction, its captured mask, channels already served.
    logic             m_busy;
    logic [NCH-1:0]   m_mask;
    logic [NCH-1:0]   m_done;
    logic [NCH-1:0]   m_ech;
    logic             m_tmo;
    int               m_wait;
    logic [CNT_W-1:0] m_cnt;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   exp_ireq;
    logic             exp_ack;
    logic [NCH-1:0]   exp_q[$];

    task automatic model_reset();
        m_busy = 1'b0; m_mask = '0; m_done = '0; m_ech = '0;
        m_tmo = 1'b0; m_wait = 0; m_cnt = '0;
    endtask

    task automatic drive(input logic req, input logic [NCH-1:0] mask,
                         input logic [NCH-1:0] ack, input logic clr);
        bus.t_ka_req = req;
        bus.t_mask   = mask;
        bus.i_ack    = ack;
        err_clr      = clr;
        pend     = (m_busy ? m_mask : mask) & ~m_done;
        exp_ireq = req ? pend : '0;
        exp_ack  = req && ((pend & ~ack) == '0);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_busy && !exp_ack && m_wait == TMO_LIMIT - 1) begin
            m_tmo = 1'b1;
            m_ech = m_ech | (m_mask & ~m_done & ~bus.i_ack);
        end else if (err_clr) begin
            m_tmo = 1'b0;
            m_ech = '0;
        end
        if (exp_ack) begin
            m_cnt  = m_cnt + CNT_W'(1);
            m_busy = 1'b0;
            m_done = '0;
            m_wait = 0;
        end else if (bus.t_ka_req) begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_mask = bus.t_mask;
                m_wait = 0;
            end else if (m_wait < TMO_LIMIT) begin
                m_wait++;
            end
            m_done = m_done | (pend & bus.i_ack);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (bus.i_req !== '0) begin errors++; $display("FAIL rst_ireq got %b want 0000", bus.i_req); end
        checks++; if (bus.t_ka_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", bus.t_ka_ack); end
        checks++; if (err_tmo !== 1'b0 || err_ch !== '0) begin errors++; $display("FAIL rst_err got %b/%b want 0/0000", err_tmo, err_ch); end
        checks++; if (txn_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", txn_cnt); end
        checks++; if (state !== KA_IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", state); end
    endtask

    task automatic test_partial_ack();
        logic [NCH-1:0] acks [6];
        acks = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 4'b1011, acks[c], 1'b0);
            checks++; if (bus.i_req !== exp_ireq) begin errors++; $display("FAIL pa_ireq c%0d got %b want %b", c, bus.i_req, exp_ireq); end
            checks++; if (bus.t_ka_ack !== (c == 5)) begin errors++; $display("FAIL pa_ack c%0d got %b want %b", c, bus.t_ka_ack, (c == 5)); end
            checks++; if (bus.i_req[2] !== 1'b0) begin errors++; $display("FAIL pa_ch2 c%0d got %b want 0", c, bus.i_req[2]); end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (txn_cnt !== 4'd1) begin errors++; $display("FAIL pa_cnt got %0d want 1", txn_cnt); end
    endtask

    task automatic test_zero_mask();
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        checks++; if (bus.t_ka_ack !== 1'b1) begin errors++; $display("FAIL zm_ack got %b want 1", bus.t_ka_ack); end
        checks++; if (bus.i_req !== '0) begin errors++; $display("FAIL zm_ireq got %b want 0000", bus.i_req); end
        tick();
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (state !== KA_IDLE) begin errors++; $display("FAIL zm_state got %0d want IDLE", state); end
        checks++; if (txn_cnt !== m_cnt) begin errors++; $display("FAIL zm_cnt got %0d want %0d", txn_cnt, m_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [NCH-1:0] masks [10];
        logic [CNT_W-1:0] start;
        masks = '{4'b0110, 4'b0110, 4'b1001, 4'b0001, 4'b1111,
                  4'b0100, 4'b0110, 4'b1010, 4'b0011, 4'b1000};
        start = m_cnt;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, masks[c], 4'b1111, 1'b0);
            checks++; if (bus.i_req !== masks[c]) begin errors++; $display("FAIL b2b_ireq c%0d got %b want %b", c, bus.i_req, masks[c]); end
            checks++; if (bus.t_ka_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack c%0d got %b want 1", c, bus.t_ka_ack); end
            tick();
            checks++; if (state !== KA_IDLE) begin errors++; $display("FAIL b2b_state c%0d got %0d want IDLE", c, state); end
        end
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (txn_cnt !== start + CNT_W'(10)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", txn_cnt, start + CNT_W'(10)); end
    endtask

    task automatic test_mask_stability();
        drive(1'b1, 4'b0001, 4'b0000, 1'b0);
        checks++; if (bus.i_req !== 4'b0001) begin errors++; $display("FAIL ms_ireq0 got %b want 0001", bus.i_req); end
        tick();
        drive(1'b1, 4'b1111, 4'b0000, 1'b0);
        checks++; if (bus.i_req !== 4'b0001) begin errors++; $display("FAIL ms_ireq1 got %b want 0001", bus.i_req); end
        tick();
        drive(1'b1, 4'b1111, 4'b1110, 1'b0);
        checks++; if (bus.t_ka_ack !== 1'b0) begin errors++; $display("FAIL ms_noack got %b want 0", bus.t_ka_ack); end
        tick();
        drive(1'b1, 4'b1111, 4'b0001, 1'b0);
        checks++; if (bus.t_ka_ack !== 1'b1 || bus.i_req !== 4'b0001) begin errors++; $display("FAIL ms_done got ack=%b ireq=%b want ack=1 ireq=0001", bus.t_ka_ack, bus.i_req); end
        tick();
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_watchdog();
        drive(1'b1, 4'b0101, 4'b0001, 1'b0);
        tick();
        for (int k = 1; k <= TMO_LIMIT + 3; k++) begin
            drive(1'b1, 4'b0101, 4'b0000, 1'b0);
            if (k == TMO_LIMIT) begin
                checks++; if (err_tmo !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", err_tmo); end
            end
            tick();
            if (k == TMO_LIMIT) begin
                checks++; if (err_tmo !== 1'b1) begin errors++; $display("FAIL wd_tmo got %b want 1", err_tmo); end
                checks++; if (err_ch !== 4'b0100) begin errors++; $display("FAIL wd_ch got %b want 0100", err_ch); end
            end
        end
        drive(1'b1, 4'b0101, 4'b0100, 1'b0);
        checks++; if (bus.t_ka_ack !== 1'b1 || bus.i_req !== 4'b0100) begin errors++; $display("FAIL wd_late got ack=%b ireq=%b want ack=1 ireq=0100", bus.t_ka_ack, bus.i_req); end
        tick();
        drive(1'b0, '0, '0, 1'b1);
        checks++; if (err_tmo !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b want 1", err_tmo); end
        tick();
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (err_tmo !== 1'b0 || err_ch !== '0) begin errors++; $display("FAIL wd_clr got %b/%b want 0/0000", err_tmo, err_ch); end
    endtask

    task automatic test_reset_mid_busy();
        drive(1'b1, 4'b0011, 4'b0000, 1'b0);
        tick();
        drive(1'b1, 4'b0011, 4'b0000, 1'b0);
        checks++; if (bus.i_req !== 4'b0011) begin errors++; $display("FAIL rb_pre got %b want 0011", bus.i_req); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.i_req !== '0 || bus.t_ka_ack !== 1'b0) begin errors++; $display("FAIL rb_async got ireq=%b ack=%b want 0000/0", bus.i_req, bus.t_ka_ack); end
        checks++; if (state !== KA_IDLE || txn_cnt !== '0) begin errors++; $display("FAIL rb_regs got state=%0d cnt=%0d want IDLE/0", state, txn_cnt); end
        bus.t_ka_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 4'b1100, 4'b0100, 1'b0);
        checks++; if (bus.i_req !== 4'b1100) begin errors++; $display("FAIL rb_new0 got %b want 1100", bus.i_req); end
        tick();
        drive(1'b1, 4'b1100, 4'b1000, 1'b0);
        checks++; if (bus.i_req !== 4'b1000 || bus.t_ka_ack !== 1'b1) begin errors++; $display("FAIL rb_new1 got ireq=%b ack=%b want 1000/1", bus.i_req, bus.t_ka_ack); end
        tick();
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (txn_cnt !== 4'd1) begin errors++; $display("FAIL rb_cnt got %0d want 1", txn_cnt); end
    endtask

    task automatic test_random();
        logic           req;
        logic           clr;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] ack;
        logic [NCH-1:0] seen;
        logic [NCH-1:0] want;
        seen = '0;
        for (int c = 0; c < 400; c++) begin
            req  = m_busy ? 1'b1 : ($urandom_range(0, 3) != 0);
            mask = NCH'($urandom_range(0, 15));
            ack  = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
            clr  = ($urandom_range(0, 19) == 0);
            if (req && !m_busy) exp_q.push_back(mask);
            drive(req, mask, ack, clr);
            checks++; if (bus.i_req !== exp_ireq) begin errors++; $display("FAIL rnd_ireq c%0d got %b want %b", c, bus.i_req, exp_ireq); end
            checks++; if (bus.t_ka_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack c%0d got %b want %b", c, bus.t_ka_ack, exp_ack); end
            seen = seen | bus.i_req;
            if (bus.t_ka_ack === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_sb c%0d unexpected ack, no open transaction", c);
                end else begin
                    want = exp_q.pop_front();
                    if (seen !== want) begin errors++; $display("FAIL rnd_sb c%0d requested %b want %b", c, seen, want); end
                end
                seen = '0;
            end
            tick();
            checks++; if (txn_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, txn_cnt, m_cnt); end
            checks++; if (err_tmo !== m_tmo || err_ch !== m_ech) begin errors++; $display("FAIL rnd_err c%0d got %b/%b want %b/%b", c, err_tmo, err_ch, m_tmo, m_ech); end
        end
        // Let any open transaction finish so the protocol check stays quiet.
        for (int c = 0; c < 4 && m_busy; c++) begin
            drive(1'b1, '0, 4'b1111, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        bus.t_ka_req = 1'b0;
        bus.t_mask   = '0;
        bus.i_ack    = '0;
        err_clr      = 1'b0;
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        test_reset();
        test_partial_ack();
        test_zero_mask();
        test_back_to_back();
        test_mask_stability();
        test_watchdog();
        test_reset_mid_busy();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ka_fork_ctrl.md
# ka_fork_ctrl

Parametrised fork/join handshake controller. It accepts one upstream req/ack transaction and fans it out to NCH downstream req/ack channels selected by a per-transaction mask. It collects every selected downstream ack and returns a single upstream ack once all of them are in. It sits between a decode stage and its NCH consumers, adds a transaction counter and a stall watchdog, and replaces fixed three-way fork controllers whose channel selection comes from a control field.

## Interface
- NCH, 4, number of downstream channels (1..16)
- TMO_W, 10, width of stall-watchdog counter
- TMO_LIMIT, 1000, cycles in BUSY before timeout flag sets (< 2**TMO_W)
- CNT_W, 16, width of completed-transaction counter
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- t_ka_req  in  1  upstream request; held until t_ka_ack
- t_ka_ack  out  1  upstream ack, combinational, one cycle per transaction
- t_mask  in  NCH  channel select; must be valid whenever t_ka_req=1 in IDLE
- i_req  out  NCH  downstream requests
- i_ack  in  NCH  downstream acks
- err_clr  in  1  clears err_tmo and err_ch
- err_tmo  out  1  sticky watchdog flag
- err_ch  out  NCH  sticky: channels still pending when the watchdog fired
- txn_cnt  out  CNT_W  completed transactions, wraps

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- Effective mask: m = t_mask in IDLE, mask_q in BUSY. mask_q <= t_mask on the IDLE→BUSY transition. Changes to t_mask during BUSY are ignored.
- Per-channel done flag done_q[i]: done_q[i] <= (done_q[i] | (i_req[i] & i_ack[i])) & ~t_ka_ack.
- i_req[i] = t_ka_req & m[i] & ~done_q[i].
- t_ka_ack = t_ka_req & AND over i of (~m[i] | done_q[i] | i_ack[i]).
- IDLE→BUSY when t_ka_req & ~t_ka_ack. BUSY→IDLE when t_ka_ack. A single-cycle transaction (all selected acks in the first cycle, or m=0) stays in IDLE.
- m=0: t_ka_ack=t_ka_req in the same cycle, no i_req asserted, txn_cnt increments.
- txn_cnt += 1 on every cycle with t_ka_ack=1. It wraps from 2**CNT_W-1 to 0.
- Watchdog wcnt:
  - Clears in IDLE and on t_ka_ack.
  - Increments each BUSY cycle without t_ka_ack and saturates at TMO_LIMIT.
  - When wcnt==TMO_LIMIT-1 and it increments: err_tmo<=1, err_ch<=err_ch | (mask_q & ~done_q & ~i_ack).
  - The transaction is not aborted; the block keeps waiting.
- err_clr clears err_tmo and err_ch. If err_clr coincides with a new timeout event, set wins.
- Upstream dropping t_ka_req before t_ka_ack is illegal; behaviour is undefined, and the bench flags it with an assertion.

## Timing
- Reset values: i_req=0, t_ka_ack=0 (t_ka_req is low during reset by protocol), err_tmo=0, err_ch=0, txn_cnt=0, done_q=0, mask_q=0, wcnt=0, state=IDLE.
- Reset mid-transaction drops all i_req immediately (async) and discards done_q.
- Latency: the ack arrives in the same cycle as the last outstanding i_ack. Minimum transaction is 1 cycle.
- Each downstream req drops the cycle after its own ack and does not re-assert within the transaction.
- Back-to-back: a new t_ka_req in the cycle after t_ka_ack starts a fresh transaction with newly sampled t_mask.
- i_ack on an unselected or already-done channel is ignored.

## Structure
- Package ka_pkg: the state enum (KA_IDLE, KA_BUSY) and shared constants for default NCH/TMO widths.
- Optional sub-module ka_fork_lane: per-channel done_q/i_req/ack-term logic, instantiated NCH times via generate. The top holds the FSM, mask_q, watchdog and counter.

## Test plan
- NCH=4, t_mask=4'b1011, acks on ch0 at cycle 1, ch3 at cycle 3, ch1 at cycle 5 → t_ka_ack high only in cycle 5; i_req[2] never high; txn_cnt=1.
- t_mask=4'b0000 with t_ka_req for 1 cycle → t_ka_ack same cycle, no i_req, state stays IDLE, txn_cnt increments.
- t_mask=4'b0110, all i_ack tied high → 1-cycle transactions back-to-back for 10 requests; txn_cnt=10; t_mask changes between them are honoured.
- Mask stability: start with t_mask=4'b0001, switch t_mask to 4'b1111 mid-BUSY → only ch0 requested; ack after ch0 alone.
- Watchdog, TMO_LIMIT=20: t_mask=4'b0101, ch0 acks, ch2 silent → err_tmo=1 and err_ch=4'b0100 after 20 BUSY cycles; a late ch2 ack still completes the transaction; err_clr clears both flags.
- Assert reset_n mid-BUSY with 2 channels pending → i_req=0 asynchronously; after release, a new transaction with a different mask completes normally.
